// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, performs a byte-lane masked access on a little-endian byte array.
module mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 17,
  parameter int LATENCY       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [3:0]               req_be,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int unsigned NLANES   = (DATA_WIDTH / 8 < 4) ? DATA_WIDTH / 8 : 4;
  localparam int unsigned DEPTH    = 1 << ADDRESS_WIDTH;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  logic [7:0]               r_mem [DEPTH];
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [3:0]               r_cnt;
  logic [3:0]               w_cnt_nxt;
  logic                     r_we;
  logic [3:0]               r_be;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_err;
  logic                     w_accept;
  logic                     w_access;
  logic                     w_misaligned;
  logic [ADDRESS_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0]    w_rd_word;

  assign w_misaligned = (r_addr[1:0] != 2'b00);
  assign w_base       = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane 0 sits at the lowest byte address of the aligned word.
  always_comb begin
    w_rd_word = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      w_rd_word[8*i +: 8] = r_mem[w_base | ADDRESS_WIDTH'(i)];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_be    <= req_be;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_access) begin
        r_rdata <= (w_misaligned || r_we) ? '0 : w_rd_word;
        r_err   <= w_misaligned;
      end
    end
  end

  // Storage has no reset; a reset during WAIT leaves r_state idle so no access fires.
  always_ff @(posedge CLK) begin
    if (w_access && r_we && !w_misaligned) begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (r_be[i]) r_mem[w_base | ADDRESS_WIDTH'(i)] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=4 instance for the main
// scenarios, LATENCY=1 instance for back-to-back throughput.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
  logic [3:0]  a_req_be = '0;
  logic [16:0] a_req_addr = '0;
  logic [31:0] a_req_wdata = '0;
  logic        a_resp_valid, a_resp_ready = 1'b0, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
  logic [3:0]  b_req_be = '0;
  logic [16:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_resp_valid, b_resp_ready = 1'b0, b_resp_err;
  logic [31:0] b_resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(17), .LATENCY(4)) u_l4 (
    .CLK(CLK), .RST(RST),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(17), .LATENCY(1)) u_l1 (
    .CLK(CLK), .RST(RST),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_be(b_req_be), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // Stimulus helper: issue one request from IDLE (called at posedge+1),
  // measure edges from acceptance to resp_valid, then complete the handshake.
  task automatic do_req(input bit sel, input logic we, input logic [3:0] be,
                        input logic [16:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    logic rv;
    if (!sel) begin
      a_req_valid = 1'b1; a_req_we = we; a_req_be = be; a_req_addr = addr; a_req_wdata = wdata;
    end else begin
      b_req_valid = 1'b1; b_req_we = we; b_req_be = be; b_req_addr = addr; b_req_wdata = wdata;
    end
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      rv = sel ? b_resp_valid : a_resp_valid;
    end while (!rv && lat < 40);
    rdata = sel ? b_resp_rdata : a_resp_rdata;
    err   = sel ? b_resp_err : a_resp_err;
    if (!sel) a_resp_ready = 1'b1; else b_resp_ready = 1'b1;
    @(posedge CLK); #1;
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=1", a_req_ready); end
    n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b exp=0", a_resp_valid); end
    n_cmp++; if (a_resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", a_resp_rdata); end
    n_cmp++; if (a_resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", a_resp_err); end
    a_req_valid = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_hold_ready got=%b exp=1", a_req_ready); end
    a_req_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b1, 4'hF, 17'h100, 32'hDEADBEEF, lat, rd, err);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err got=%b exp=0", err); end
    do_req(1'b0, 1'b0, 4'h0, 17'h100, 32'h0, lat, rd, err);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rd_latency got=%0d exp=4", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err got=%b exp=0", err); end
  endtask

  task automatic test_partial_write();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b1, 4'b0011, 17'h100, 32'h00001234, lat, rd, err);
    do_req(1'b0, 1'b0, 4'hF, 17'h100, 32'h0, lat, rd, err);
    n_cmp++; if (rd !== 32'hDEAD1234) begin n_bad++; $display("FAIL partial_rd got=%h exp=dead1234", rd); end
    do_req(1'b0, 1'b1, 4'b0000, 17'h100, 32'h0, lat, rd, err);
    n_cmp++; if (lat !== 4 || err !== 1'b0) begin n_bad++; $display("FAIL zero_be_resp got=lat%0d/err%b exp=lat4/err0", lat, err); end
    do_req(1'b0, 1'b0, 4'h0, 17'h100, 32'h0, lat, rd, err);
    n_cmp++; if (rd !== 32'hDEAD1234) begin n_bad++; $display("FAIL zero_be_rd got=%h exp=dead1234", rd); end
  endtask

  task automatic test_backpressure();
    int lat;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_be = 4'hF; a_req_addr = 17'h100; a_req_wdata = '0;
    @(posedge CLK); #1;
    lat = 0;
    while (!a_resp_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (a_resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, a_resp_valid); end
      n_cmp++; if (a_resp_rdata !== 32'hDEAD1234) begin n_bad++; $display("FAIL bp_rdata[%0d] got=%h exp=dead1234", c, a_resp_rdata); end
      n_cmp++; if (a_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", c, a_req_ready); end
      @(posedge CLK); #1;
    end
    a_resp_ready = 1'b1;
    @(posedge CLK); #1;
    a_resp_ready = 1'b0;
    n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_after_hs_valid got=%b exp=0", a_resp_valid); end
    n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_after_hs_ready got=%b exp=1", a_req_ready); end
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    n_cmp++; if (a_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_reaccept got=%b exp=0", a_req_ready); end
    lat = 0;
    while (!a_resp_valid && lat < 40) begin @(posedge CLK); #1; lat++; end
    n_cmp++; if (lat !== 4 || a_resp_rdata !== 32'hDEAD1234) begin n_bad++; $display("FAIL bp_second got=lat%0d/%h exp=lat4/dead1234", lat, a_resp_rdata); end
    a_resp_ready = 1'b1;
    @(posedge CLK); #1;
    a_resp_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b1, 4'hF, 17'h102, 32'hFFFFFFFF, lat, rd, err);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mis_wr_err got=%b exp=1", err); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_wr_rdata got=%h exp=0", rd); end
    do_req(1'b0, 1'b0, 4'hF, 17'h101, 32'h0, lat, rd, err);
    n_cmp++; if (err !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mis_rd got=err%b/%h exp=err1/0", err, rd); end
    do_req(1'b0, 1'b0, 4'hF, 17'h100, 32'h0, lat, rd, err);
    n_cmp++; if (rd !== 32'hDEAD1234 || err !== 1'b0) begin n_bad++; $display("FAIL mis_unchanged got=%h/err%b exp=dead1234/err0", rd, err); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b1, 4'hF, 17'h200, 32'h11223344, lat, rd, err);
    do_req(1'b0, 1'b0, 4'hF, 17'h200, 32'h0, lat, rd, err);
    n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rm_prior got=%h exp=11223344", rd); end
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 4'hF; a_req_addr = 17'h200; a_req_wdata = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    a_req_valid = 1'b0;
    n_cmp++; if (a_req_ready !== 1'b0) begin n_bad++; $display("FAIL rm_in_wait got=%b exp=0", a_req_ready); end
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    n_cmp++; if (a_req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_async_ready got=%b exp=1", a_req_ready); end
    n_cmp++; if (a_resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_async_rdata got=%h exp=0", a_resp_rdata); end
    n_cmp++; if (a_resp_valid !== 1'b0 || a_resp_err !== 1'b0) begin n_bad++; $display("FAIL rm_async_valid_err got=%b%b exp=00", a_resp_valid, a_resp_err); end
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_held_valid[%0d] got=%b exp=0", c, a_resp_valid); end
    end
    RST = 1'b1;
    do_req(1'b0, 1'b0, 4'hF, 17'h200, 32'h0, lat, rd, err);
    n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rm_after got=%h exp=11223344", rd); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rm_after_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic err;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_be = 4'hF; b_req_addr = 17'h40; b_req_wdata = 32'hCAFEF00D;
    b_resp_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK); #1;
      n_cmp++; if (b_resp_valid !== ((k % 3) == 2)) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", k, b_resp_valid, ((k % 3) == 2)); end
      n_cmp++; if (b_req_ready !== ((k % 3) == 0)) begin n_bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", k, b_req_ready, ((k % 3) == 0)); end
    end
    b_req_valid = 1'b0;
    b_resp_ready = 1'b0;
    @(posedge CLK); #1;
    do_req(1'b1, 1'b0, 4'hF, 17'h40, 32'h0, lat, rd, err);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL l1_latency got=%0d exp=1", lat); end
    n_cmp++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin n_bad++; $display("FAIL l1_rd got=%h/err%b exp=cafef00d/err0", rd, err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
